// File: rtl/core_pkg.sv
// Shared core types for the data-memory path: access sizes, LSU FSM states
// and the misalignment rule used when an access is accepted.
package core_pkg;

    typedef enum logic [1:0] {
        LSU_B = 2'b00,
        LSU_H = 2'b01,
        LSU_W = 2'b10
    } lsu_size_e;

    typedef enum logic [2:0] {
        IDLE,
        REQ1,
        WAIT1,
        REQ2,
        WAIT2
    } lsu_state_e;

    // A half at offset 1 still fits in one word, so only offset 3 crosses a boundary
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == LSU_H) && (off == 2'd3)) || ((size == LSU_W) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: byte enables and store data shifted into a
// two-word window, and load data pulled back out of it and extended.
module lsu_align
    import core_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]         off,
    input  lsu_size_e          size,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [WIDTH-1:0]   rdata_lo,
    input  logic [WIDTH-1:0]   rdata_hi,
    output logic [7:0]         be8,
    output logic [2*WIDTH-1:0] wd64,
    output logic [WIDTH-1:0]   rdata_ext
);

    logic [3:0]       mask;
    logic [WIDTH-1:0] rd_shift;

    always_comb begin
        mask = 4'b0000;
        case (size)
            LSU_B:   mask = 4'b0001;
            LSU_H:   mask = 4'b0011;
            LSU_W:   mask = 4'b1111;
            default: mask = 4'b0000;
        endcase

        be8  = {4'b0000, mask} << off;
        wd64 = {{WIDTH{1'b0}}, wdata} << {off, 3'b000};

        // Upper word of the shifted window can never hold a requested byte
        rd_shift = WIDTH'({rdata_hi, rdata_lo} >> {off, 3'b000});

        case (size)
            LSU_B:   rdata_ext = {{(WIDTH-8){is_signed & rd_shift[7]}}, rd_shift[7:0]};
            LSU_H:   rdata_ext = {{(WIDTH-16){is_signed & rd_shift[15]}}, rd_shift[15:0]};
            default: rdata_ext = rd_shift;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory port of the core: runs the req/gnt/rvalid handshake, splits
// misaligned accesses into two aligned words and stalls the pipeline meanwhile.
module load_store_unit
    import core_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             lsu_req_i,
    input  logic             lsu_we_i,
    input  logic [1:0]       lsu_size_i,
    input  logic             lsu_signed_i,
    input  logic [WIDTH-1:0] lsu_addr_i,
    input  logic [WIDTH-1:0] lsu_wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [WIDTH-1:0] load_result_o,
    output logic             data_req_o,
    input  logic             data_gnt_i,
    output logic             data_we_o,
    output logic [3:0]       data_be_o,
    output logic [WIDTH-1:0] data_addr_o,
    output logic [WIDTH-1:0] data_wdata_o,
    input  logic             data_rvalid_i,
    input  logic [WIDTH-1:0] data_rdata_i,
    input  logic             data_err_i
);

    lsu_state_e       state_q, state_d;
    lsu_size_e        size_q;
    logic             we_q, signed_q, bad_q, split_q;
    logic [WIDTH-1:0] addr_q, wdata_q, rdata1_q, load_result_q;

    logic             req_illegal, req_misaligned;
    logic             finish, phase2;
    logic [WIDTH-1:0] word_addr, rdata_lo, rdata_hi, rdata_ext;
    logic [7:0]       be8;
    logic [2*WIDTH-1:0] wd64;

    assign req_illegal    = (lsu_size_i == 2'b11);
    assign req_misaligned = lsu_misaligned(lsu_size_i, lsu_addr_i[1:0]);
    assign word_addr      = {addr_q[WIDTH-1:2], 2'b00};

    // Second beat pairs the saved first word with the live response
    assign rdata_lo = (state_q == WAIT2) ? rdata1_q : data_rdata_i;
    assign rdata_hi = (state_q == WAIT2) ? data_rdata_i : '0;

    lsu_align #(.WIDTH(WIDTH)) u_align (
        .off       (addr_q[1:0]),
        .size      (size_q),
        .is_signed (signed_q),
        .wdata     (wdata_q),
        .rdata_lo  (rdata_lo),
        .rdata_hi  (rdata_hi),
        .be8       (be8),
        .wd64      (wd64),
        .rdata_ext (rdata_ext)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            size_q        <= LSU_B;
            we_q          <= 1'b0;
            signed_q      <= 1'b0;
            bad_q         <= 1'b0;
            split_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata1_q      <= '0;
            load_result_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && lsu_req_i) begin
                size_q   <= req_illegal ? LSU_B : lsu_size_e'(lsu_size_i);
                we_q     <= lsu_we_i;
                signed_q <= lsu_signed_i;
                bad_q    <= req_illegal || (req_misaligned && !MISALIGN_EN);
                split_q  <= req_misaligned && MISALIGN_EN && !req_illegal;
                addr_q   <= lsu_addr_i;
                wdata_q  <= lsu_wdata_i;
            end
            if ((state_q == WAIT1) && data_rvalid_i) begin
                rdata1_q <= data_rdata_i;
            end
            if (finish && !we_q && !data_err_i) begin
                load_result_q <= rdata_ext;
            end
        end
    end

    // A rejected request (bad_q) parks in REQ1 for one cycle purely to report the error
    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        err_o   = 1'b0;
        finish  = 1'b0;
        phase2  = 1'b0;
        data_req_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (lsu_req_i) begin
                    busy_o  = 1'b1;
                    state_d = REQ1;
                end
            end
            REQ1: begin
                if (bad_q) begin
                    done_o  = 1'b1;
                    err_o   = 1'b1;
                    state_d = IDLE;
                end else begin
                    busy_o     = 1'b1;
                    data_req_o = 1'b1;
                    if (data_gnt_i) state_d = WAIT1;
                end
            end
            WAIT1: begin
                busy_o = 1'b1;
                if (data_rvalid_i) begin
                    if (split_q && !data_err_i) begin
                        state_d = REQ2;
                    end else begin
                        busy_o  = 1'b0;
                        done_o  = 1'b1;
                        err_o   = data_err_i;
                        finish  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            REQ2: begin
                busy_o     = 1'b1;
                data_req_o = 1'b1;
                phase2     = 1'b1;
                if (data_gnt_i) state_d = WAIT2;
            end
            WAIT2: begin
                busy_o = 1'b1;
                if (data_rvalid_i) begin
                    busy_o  = 1'b0;
                    done_o  = 1'b1;
                    err_o   = data_err_i;
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus fields are forced to zero whenever no request is on the bus
    always_comb begin
        data_we_o    = 1'b0;
        data_be_o    = 4'b0000;
        data_addr_o  = '0;
        data_wdata_o = '0;
        if (data_req_o) begin
            data_we_o    = we_q;
            data_be_o    = phase2 ? be8[7:4] : be8[3:0];
            data_addr_o  = phase2 ? (word_addr + WIDTH'(4)) : word_addr;
            data_wdata_o = phase2 ? wd64[2*WIDTH-1:WIDTH] : wd64[WIDTH-1:0];
        end
    end

    assign load_result_o = (finish && !we_q && !data_err_i) ? rdata_ext : load_result_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a word-addressed memory responder on the
// data bus, a vector table of loads/stores, and hand-written corner sequences.
module tb_load_store_unit;
    import core_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        lsu_req_i = 1'b0;
    logic        lsu_we_i = 1'b0;
    logic [1:0]  lsu_size_i = 2'b00;
    logic        lsu_signed_i = 1'b0;
    logic [31:0] lsu_addr_i = '0;
    logic [31:0] lsu_wdata_i = '0;
    logic        busy_o, done_o, err_o;
    logic [31:0] load_result_o;
    logic        data_req_o, data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic        data_gnt_i = 1'b0;
    logic        data_rvalid_i = 1'b0;
    logic [31:0] data_rdata_i = '0;
    logic        data_err_i = 1'b0;

    load_store_unit #(.WIDTH(32), .MISALIGN_EN(1'b1)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .lsu_req_i     (lsu_req_i),
        .lsu_we_i      (lsu_we_i),
        .lsu_size_i    (lsu_size_i),
        .lsu_signed_i  (lsu_signed_i),
        .lsu_addr_i    (lsu_addr_i),
        .lsu_wdata_i   (lsu_wdata_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .load_result_o (load_result_o),
        .data_req_o    (data_req_o),
        .data_gnt_i    (data_gnt_i),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_addr_o   (data_addr_o),
        .data_wdata_o  (data_wdata_o),
        .data_rvalid_i (data_rvalid_i),
        .data_rdata_i  (data_rdata_i),
        .data_err_i    (data_err_i)
    );

    always #5 clk_i = ~clk_i;

    // Responder configuration, written only by the test sequence
    int          gnt_wait_cfg = 0;
    int          rvalid_delay_cfg = 0;
    logic        err_en_cfg = 1'b0;
    logic [31:0] err_addr_cfg = '0;

    // Responder state, written only by the responder process
    logic [31:0] mem [0:1023];
    int          resp_cnt = 0;
    int          gnt_wait_cnt = 0;
    logic [31:0] resp_data = '0;
    logic        resp_err = 1'b0;
    int          grant_cnt = 0;
    logic [31:0] log_addr  [0:255];
    logic [3:0]  log_be    [0:255];
    logic [31:0] log_wdata [0:255];

    always @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_gnt_i    = 1'b0;
            data_rvalid_i = 1'b0;
            data_rdata_i  = '0;
            data_err_i    = 1'b0;
            resp_cnt      = 0;
            gnt_wait_cnt  = gnt_wait_cfg;
        end else begin
            data_gnt_i    = 1'b0;
            data_rvalid_i = 1'b0;
            data_rdata_i  = '0;
            data_err_i    = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt = resp_cnt - 1;
                if (resp_cnt == 0) begin
                    data_rvalid_i = 1'b1;
                    data_rdata_i  = resp_data;
                    data_err_i    = resp_err;
                end
            end
            if (!data_req_o) begin
                gnt_wait_cnt = gnt_wait_cfg;
            end else if (gnt_wait_cnt > 0) begin
                gnt_wait_cnt = gnt_wait_cnt - 1;
            end else begin
                data_gnt_i = 1'b1;
                if (grant_cnt < 256) begin
                    log_addr[grant_cnt]  = data_addr_o;
                    log_be[grant_cnt]    = data_be_o;
                    log_wdata[grant_cnt] = data_wdata_o;
                end
                grant_cnt = grant_cnt + 1;
                resp_err  = err_en_cfg && (data_addr_o == err_addr_cfg);
                if (data_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (data_be_o[b]) mem[data_addr_o[11:2]][8*b +: 8] = data_wdata_o[8*b +: 8];
                    resp_data = '0;
                end else begin
                    resp_data = mem[data_addr_o[11:2]];
                end
                resp_cnt = 1 + rvalid_delay_cfg;
            end
        end
    end

    int total = 0;
    int bad   = 0;
    int base_grant = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Presents one request in the accept cycle and drops it after the edge that takes it
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk_i);
        base_grant   = grant_cnt;
        lsu_req_i    = 1'b1;
        lsu_we_i     = we;
        lsu_size_i   = size;
        lsu_signed_i = sgn;
        lsu_addr_i   = addr;
        lsu_wdata_i  = wdata;
        #1;
        checkOutput("busy_on_accept", 32'(busy_o), 32'd1);
        @(posedge clk_i);
        #1;
        lsu_req_i = 1'b0;
    endtask

    task automatic waitDone(input int start_cyc, output int lat, output logic got_err,
                            output logic [31:0] res, output logic [31:0] res_held);
        int  c;
        bit  seen;
        c = start_cyc;
        seen = 1'b0;
        lat = -1;
        got_err = 1'b0;
        res = '0;
        res_held = '0;
        while (!seen && c < 64) begin
            @(negedge clk_i);
            #1;
            c++;
            if (done_o) begin
                seen    = 1'b1;
                lat     = c;
                got_err = err_o;
                res     = load_result_o;
            end
        end
        checkOutput("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            @(negedge clk_i);
            #1;
            checkOutput("done_single", 32'(done_o), 32'd0);
            checkOutput("idle_not_busy", 32'(busy_o), 32'd0);
            res_held = load_result_o;
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp_res;
        logic        exp_err;
        int          exp_lat;
        int          exp_grants;
    } vec_t;

    vec_t vq[$];

    initial begin
        int          lat;
        logic        e;
        logic [31:0] r, rh;

        // Stores double as memory preload; loads check assembly against hand-computed words
        vq.push_back('{1'b1, LSU_W, 1'b0, 32'h100, 32'h80AABBCC, 1'b0, 32'h0,        1'b0, 2, 1});
        vq.push_back('{1'b0, LSU_B, 1'b0, 32'h103, 32'h0,        1'b1, 32'h00000080, 1'b0, 2, 1});
        vq.push_back('{1'b0, LSU_B, 1'b1, 32'h103, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0, 2, 1});
        vq.push_back('{1'b0, LSU_H, 1'b0, 32'h102, 32'h0,        1'b1, 32'h000080AA, 1'b0, 2, 1});
        vq.push_back('{1'b0, LSU_H, 1'b1, 32'h101, 32'h0,        1'b1, 32'hFFFFAABB, 1'b0, 2, 1});
        vq.push_back('{1'b0, LSU_W, 1'b0, 32'h100, 32'h0,        1'b1, 32'h80AABBCC, 1'b0, 2, 1});
        vq.push_back('{1'b0, LSU_B, 1'b0, 32'h100, 32'h0,        1'b1, 32'h000000CC, 1'b0, 2, 1});
        vq.push_back('{1'b0, LSU_B, 1'b1, 32'h102, 32'h0,        1'b1, 32'hFFFFFFAA, 1'b0, 2, 1});
        vq.push_back('{1'b1, LSU_W, 1'b0, 32'h0FC, 32'h12345678, 1'b0, 32'h0,        1'b0, 2, 1});
        vq.push_back('{1'b1, LSU_B, 1'b0, 32'h100, 32'hDEAD0085, 1'b0, 32'h0,        1'b0, 2, 1});
        vq.push_back('{1'b0, LSU_H, 1'b1, 32'h0FF, 32'h0,        1'b1, 32'hFFFF8512, 1'b0, 4, 2});
        vq.push_back('{1'b0, LSU_H, 1'b0, 32'h0FF, 32'h0,        1'b1, 32'h00008512, 1'b0, 4, 2});
        vq.push_back('{1'b1, LSU_W, 1'b0, 32'h104, 32'h88776655, 1'b0, 32'h0,        1'b0, 2, 1});
        vq.push_back('{1'b0, LSU_W, 1'b0, 32'h101, 32'h0,        1'b1, 32'h5580AABB, 1'b0, 4, 2});
        vq.push_back('{1'b1, LSU_H, 1'b0, 32'h103, 32'h1234BEEF, 1'b0, 32'h0,        1'b0, 4, 2});
        vq.push_back('{1'b0, LSU_W, 1'b0, 32'h100, 32'h0,        1'b1, 32'hEFAABB85, 1'b0, 2, 1});
        vq.push_back('{1'b0, LSU_W, 1'b0, 32'h104, 32'h0,        1'b1, 32'h887766BE, 1'b0, 2, 1});
        vq.push_back('{1'b0, LSU_H, 1'b1, 32'h103, 32'h0,        1'b1, 32'hFFFFBEEF, 1'b0, 4, 2});
        vq.push_back('{1'b0, 2'b11, 1'b0, 32'h100, 32'h0,        1'b0, 32'h0,        1'b1, 1, 0});
        vq.push_back('{1'b0, LSU_B, 1'b0, 32'h106, 32'h0,        1'b1, 32'h00000077, 1'b0, 2, 1});

        // Reset values
        #1;
        checkOutput("rst_busy",   32'(busy_o), 32'd0);
        checkOutput("rst_done",   32'(done_o), 32'd0);
        checkOutput("rst_err",    32'(err_o), 32'd0);
        checkOutput("rst_req",    32'(data_req_o), 32'd0);
        checkOutput("rst_we",     32'(data_we_o), 32'd0);
        checkOutput("rst_be",     32'(data_be_o), 32'd0);
        checkOutput("rst_addr",   data_addr_o, 32'd0);
        checkOutput("rst_wdata",  data_wdata_o, 32'd0);
        checkOutput("rst_result", load_result_o, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        foreach (vq[i]) begin
            applyStimulus(vq[i].we, vq[i].size, vq[i].sgn, vq[i].addr, vq[i].wdata);
            waitDone(0, lat, e, r, rh);
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vq[i].exp_lat));
            checkOutput($sformatf("vec%0d_err", i), 32'(e), 32'(vq[i].exp_err));
            checkOutput($sformatf("vec%0d_grants", i), 32'(grant_cnt - base_grant), 32'(vq[i].exp_grants));
            if (vq[i].chk) begin
                checkOutput($sformatf("vec%0d_result", i), r, vq[i].exp_res);
                checkOutput($sformatf("vec%0d_result_held", i), rh, vq[i].exp_res);
            end
        end

        // Misaligned store: lanes of both beats
        applyStimulus(1'b1, LSU_W, 1'b0, 32'h202, 32'h11223344);
        waitDone(0, lat, e, r, rh);
        checkOutput("sw_split_latency", 32'(lat), 32'd4);
        checkOutput("sw_split_grants", 32'(grant_cnt - base_grant), 32'd2);
        checkOutput("sw_a1_addr",  log_addr[base_grant], 32'h200);
        checkOutput("sw_a1_be",    32'(log_be[base_grant]), 32'b1100);
        checkOutput("sw_a1_wdata", log_wdata[base_grant], 32'h33440000);
        checkOutput("sw_a2_addr",  log_addr[base_grant+1], 32'h204);
        checkOutput("sw_a2_be",    32'(log_be[base_grant+1]), 32'b0011);
        checkOutput("sw_a2_wdata", log_wdata[base_grant+1], 32'h00001122);
        applyStimulus(1'b0, LSU_W, 1'b0, 32'h202, 32'h0);
        waitDone(0, lat, e, r, rh);
        checkOutput("lw_split_result", r, 32'h11223344);
        applyStimulus(1'b0, LSU_B, 1'b0, 32'h103, 32'h0);
        waitDone(0, lat, e, r, rh);
        checkOutput("lbu_be", 32'(log_be[base_grant]), 32'b1000);
        checkOutput("lbu_addr", log_addr[base_grant], 32'h100);
        checkOutput("lbu_result", r, 32'h000000EF);

        // Grant withheld for three cycles
        gnt_wait_cfg = 3;
        applyStimulus(1'b0, LSU_W, 1'b0, 32'h100, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_i);
            #1;
            checkOutput($sformatf("stall%0d_req", k),  32'(data_req_o), 32'd1);
            checkOutput($sformatf("stall%0d_addr", k), data_addr_o, 32'h100);
            checkOutput($sformatf("stall%0d_be", k),   32'(data_be_o), 32'hF);
            checkOutput($sformatf("stall%0d_busy", k), 32'(busy_o), 32'd1);
            checkOutput($sformatf("stall%0d_done", k), 32'(done_o), 32'd0);
        end
        waitDone(3, lat, e, r, rh);
        gnt_wait_cfg = 0;
        checkOutput("stall_latency", 32'(lat), 32'd5);
        checkOutput("stall_result", r, 32'hEFAABB85);

        // Error on first beat of a wrapping split, then the same access cleanly
        applyStimulus(1'b1, LSU_W, 1'b0, 32'hFFFFFFFC, 32'h56781234);
        waitDone(0, lat, e, r, rh);
        applyStimulus(1'b1, LSU_W, 1'b0, 32'h00000000, 32'hAAAA9ABC);
        waitDone(0, lat, e, r, rh);
        err_en_cfg   = 1'b1;
        err_addr_cfg = 32'hFFFFFFFC;
        applyStimulus(1'b0, LSU_W, 1'b0, 32'hFFFFFFFE, 32'h0);
        waitDone(0, lat, e, r, rh);
        checkOutput("buserr_err", 32'(e), 32'd1);
        checkOutput("buserr_latency", 32'(lat), 32'd2);
        checkOutput("buserr_grants", 32'(grant_cnt - base_grant), 32'd1);
        checkOutput("buserr_no_req", 32'(data_req_o), 32'd0);
        err_en_cfg = 1'b0;
        applyStimulus(1'b0, LSU_W, 1'b0, 32'hFFFFFFFE, 32'h0);
        waitDone(0, lat, e, r, rh);
        checkOutput("wrap_err", 32'(e), 32'd0);
        checkOutput("wrap_latency", 32'(lat), 32'd4);
        checkOutput("wrap_a1_addr", log_addr[base_grant], 32'hFFFFFFFC);
        checkOutput("wrap_a2_addr", log_addr[base_grant+1], 32'h00000000);
        checkOutput("wrap_result", r, 32'h9ABC5678);

        // Reset while waiting for the response
        rvalid_delay_cfg = 5;
        applyStimulus(1'b0, LSU_W, 1'b0, 32'h100, 32'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        checkOutput("wait1_busy", 32'(busy_o), 32'd1);
        checkOutput("wait1_no_req", 32'(data_req_o), 32'd0);
        rst_ni = 1'b0;
        #1;
        checkOutput("midrst_busy",   32'(busy_o), 32'd0);
        checkOutput("midrst_done",   32'(done_o), 32'd0);
        checkOutput("midrst_err",    32'(err_o), 32'd0);
        checkOutput("midrst_req",    32'(data_req_o), 32'd0);
        checkOutput("midrst_we",     32'(data_we_o), 32'd0);
        checkOutput("midrst_be",     32'(data_be_o), 32'd0);
        checkOutput("midrst_addr",   data_addr_o, 32'd0);
        checkOutput("midrst_wdata",  data_wdata_o, 32'd0);
        checkOutput("midrst_result", load_result_o, 32'd0);
        rvalid_delay_cfg = 0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        applyStimulus(1'b0, LSU_W, 1'b0, 32'h100, 32'h0);
        waitDone(0, lat, e, r, rh);
        checkOutput("postrst_latency", 32'(lat), 32'd2);
        checkOutput("postrst_err", 32'(e), 32'd0);
        checkOutput("postrst_result", r, 32'hEFAABB85);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
